exec_unit_mc: RTL and testbench
===============================

Name: exec_unit_mc

Overview:
- Parametrised, multi-cycle execute stage for the pipelined core. Successor to the current combinational execute stage.
- Adds configurable datapath width and an EX/MEM output register with valid/ready handshake.
- Adds an iterative shift-add multiplier and flush support for mispredict recovery.
- Sits between decode/regfile-read and the memory stage. Resolves branch/jump targets and the PC-select.

Parameters:
- DW, 16, datapath width for operands, PC and result (DW >= 4).
- PC_INC, 2, PC increment for fall-through next PC.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- flush  in  1  synchronous kill of in-flight op and output register
- in_valid  in  1  operation presented
- in_ready  out  1  unit accepts an operation this cycle
- op  in  4  operation code (see Behaviour)
- brcond  in  2  branch condition: 0 EQZ, 1 NEZ, 2 LTZ, 3 GEZ
- a  in  DW  operand A (Rs)
- b  in  DW  operand B (Rt or selected immediate)
- imm  in  DW  sign-extended displacement for BR/JR
- pc  in  DW  PC of this instruction
- out_valid  out  1  output register holds a result
- out_ready  in  1  downstream consumes result
- result  out  DW  registered ALU/MUL result
- pc_next  out  DW  registered next PC
- pc_sel  out  1  registered: 1 = redirect fetch to pc_next
- busy  out  1  multiplier iterating

Behaviour:
- Reset (rst low, async): state IDLE, out_valid 0, result 0, pc_next 0, pc_sel 0, busy 0, iteration counter 0.
- Handshake:
  - in_ready = (state==IDLE) & (~out_valid | out_ready) & ~flush.
  - An op is accepted when in_valid & in_ready.
  - The output register holds stable while out_valid & ~out_ready.
- Ops, all mod 2^DW:
  - 0 ADD a+b; 1 SUB a-b; 2 AND; 3 OR; 4 XOR.
  - 5 SLL a<<b[log2 DW-1:0]; 6 SRL logical; 7 ROL rotate left.
  - 8 SEQ (a==b); 9 SLT signed a<b; 10 SLE signed a<=b; 11 SCO carry-out of a+b. Set ops write 1 or 0 zero-extended.
  - 12 BR: result 0; taken per brcond on signed a; pc_next = taken ? pc+imm : pc+PC_INC; pc_sel = taken.
  - 13 JR: result = pc+PC_INC (link value); pc_next = a+imm; pc_sel 1.
  - 14 MUL: low DW bits of a*b, unsigned (equals signed low half).
  - 15: see Optional Feature.
- Non-branch ops: pc_next = pc+PC_INC, pc_sel 0.
- Single-cycle ops (all except 14/15): latency 1. Result appears with out_valid the cycle after acceptance.
- FSM states: IDLE, MUL (DIV with feature).
  - IDLE to MUL on accepting op 14: load multiplicand, multiplier, clear accumulator, count=0, busy=1.
  - In MUL, each cycle: if multiplier LSB set, acc += multiplicand; multiplicand <<= 1, multiplier >>= 1, count++.
  - After DW iterations, load the output register (out_valid=1), clear busy, return to IDLE.
  - MUL latency = DW+1 cycles from acceptance to out_valid. in_ready is 0 throughout.
  - Early termination is not permitted: latency is fixed.
  - MUL never completes while out_valid & ~out_ready. Acceptance guaranteed space; the register drains only via out_ready.
- Back-to-back: with out_ready=1, one single-cycle op is accepted per cycle.
- Flush (synchronous, highest priority):
  - Next edge: out_valid 0, pc_sel 0, state IDLE, busy 0.
  - An in_valid in the flush cycle is not accepted. result and pc_next keep their last values.
- Reset mid-MUL: immediate return to reset values; no partial result appears.
- Overflow is ignored for all arithmetic. The SUB/SLT/SLE sign comparison uses the DW+1-bit difference to avoid overflow error.

Optional Feature:
- Macro EXEC_UNIT_DIV_EN.
- Defined: op 15 = unsigned restoring DIV, a/b quotient. DW iterations in state DIV, latency DW+1, in_ready 0 and busy 1 while iterating. b==0 gives result all-ones in the same latency.
- Undefined: op 15 is a single-cycle op with result 0, pc_sel 0; no DIV state or divider logic is built.

Test Plan:
- Reset mid-MUL:
  - Assert rst low during MUL iteration 5 -> out_valid 0, busy 0, in_ready 1 after release.
  - Then ADD 0x7FFF+0x0001 -> result 0x8000 one cycle later.
- Back-to-back with out_ready=1:
  - SUB 5-7 -> 0xFFFE; SLT 0xFFFE<0x0001 -> 1; SCO 0xFFFF+0x0001 -> 1.
  - One result per cycle, pc_next = pc+2.
- MUL with DW=16:
  - 0x0123*0x0010 -> 0x1230; out_valid exactly 17 cycles after acceptance.
  - in_ready 0 for the whole interval; 0xFFFF*0xFFFF -> 0x0001.
- Branches:
  - BR EQZ a=0, pc=0x0100, imm=0xFFF0 -> pc_next 0x00F0, pc_sel 1.
  - BR NEZ a=0 -> pc_next 0x0102, pc_sel 0.
  - JR a=0x0200, imm=4 -> pc_next 0x0204, result 0x0102, pc_sel 1.
- Backpressure and flush:
  - Hold out_ready=0 with a result pending -> result and out_valid stable, in_ready 0.
  - Assert flush -> out_valid 0 next cycle; the in_valid in the flush cycle is dropped.
- EXEC_UNIT_DIV_EN defined: 100/7 -> 14 after 17 cycles; 5/0 -> 0xFFFF.
- EXEC_UNIT_DIV_EN undefined: op 15 -> 0 in 1 cycle.

Source files
------------

// File: rtl/exec_unit_mc_if.sv
// Interface bundle for exec_unit_mc: issue handshake, operands, registered EX/MEM outputs.
// The design side uses the slave modport; the issuing/consuming side uses master.
interface exec_unit_mc_if #(
  parameter int DW = 16
);
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    op;
  logic [1:0]    brcond;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic [DW-1:0] imm;
  logic [DW-1:0] pc;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] result;
  logic [DW-1:0] pc_next;
  logic          pc_sel;
  logic          busy;
  logic [1:0]    dbg_state;

  modport slave (
    input  flush, in_valid, op, brcond, a, b, imm, pc, out_ready,
    output in_ready, out_valid, result, pc_next, pc_sel, busy, dbg_state
  );

  modport master (
    output flush, in_valid, op, brcond, a, b, imm, pc, out_ready,
    input  in_ready, out_valid, result, pc_next, pc_sel, busy, dbg_state
  );
endinterface

// File: rtl/exec_unit_mc.sv
// Multi-cycle execute stage: single-cycle ALU/branch ops, iterative shift-add MUL, EX/MEM register.
// Optional unsigned restoring divider on op 15 when EXEC_UNIT_DIV_EN is defined.
module exec_unit_mc #(
  parameter int DW     = 16,
  parameter int PC_INC = 2
) (
  input  logic            clk,
  input  logic            rst,
  exec_unit_mc_if.slave   bus
);

  localparam int SW = $clog2(DW);
  localparam int CW = $clog2(DW) + 1;

`ifdef EXEC_UNIT_DIV_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1} state_t;
`endif

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_out_valid;
  logic [DW-1:0] r_result;
  logic [DW-1:0] r_pc_next;
  logic          r_pc_sel;
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_mcand;
  logic [DW-1:0] r_mplier;
  logic [DW-1:0] r_acc;
  logic [DW-1:0] r_mc_pcn;

  logic          w_in_ready;
  logic          w_accept;
  logic          w_is_mc;
  logic          w_last;
  logic          w_mc_done;
  logic [DW-1:0] w_mc_res;
  logic [DW-1:0] w_pc_inc;
  logic [DW:0]   w_sum;
  logic [DW:0]   w_diff;
  logic          w_eq;
  logic          w_lt;
  logic [SW-1:0] w_sh;
  logic [DW-1:0] w_rol;
  logic          w_taken;
  logic [DW-1:0] w_res;
  logic [DW-1:0] w_pcn;
  logic          w_sel;
  logic [DW-1:0] w_mul_acc;

  // Valid/ready: an op transfers on in_valid & in_ready; a result transfers on
  // out_valid & out_ready, and the output register is frozen while out_valid & ~out_ready.
  assign w_in_ready = (r_state == S_IDLE) && (!r_out_valid || bus.out_ready) && !bus.flush;
  assign w_accept   = bus.in_valid && w_in_ready;

`ifdef EXEC_UNIT_DIV_EN
  assign w_is_mc = (bus.op == 4'd14) || (bus.op == 4'd15);
`else
  assign w_is_mc = (bus.op == 4'd14);
`endif

  assign w_last    = (r_cnt == CW'(DW - 1));
  assign w_mc_done = (r_state != S_IDLE) && w_last;

  // Single-cycle datapath
  assign w_pc_inc = bus.pc + DW'(PC_INC);
  assign w_sum    = {1'b0, bus.a} + {1'b0, bus.b};
  // Sign-extended DW+1-bit difference keeps the signed compare correct on overflow.
  assign w_diff   = {bus.a[DW-1], bus.a} - {bus.b[DW-1], bus.b};
  assign w_eq     = (bus.a == bus.b);
  assign w_lt     = w_diff[DW];
  assign w_sh     = bus.b[SW-1:0];
  assign w_rol    = (bus.a << w_sh) | (bus.a >> (DW - int'(w_sh)));

  always_comb begin
    w_taken = 1'b0;
    case (bus.brcond)
      2'd0:    w_taken = (bus.a == '0);
      2'd1:    w_taken = (bus.a != '0);
      2'd2:    w_taken = bus.a[DW-1];
      default: w_taken = !bus.a[DW-1];
    endcase
  end

  always_comb begin
    w_res = '0;
    w_pcn = w_pc_inc;
    w_sel = 1'b0;
    case (bus.op)
      4'd0:  w_res = w_sum[DW-1:0];
      4'd1:  w_res = w_diff[DW-1:0];
      4'd2:  w_res = bus.a & bus.b;
      4'd3:  w_res = bus.a | bus.b;
      4'd4:  w_res = bus.a ^ bus.b;
      4'd5:  w_res = bus.a << w_sh;
      4'd6:  w_res = bus.a >> w_sh;
      4'd7:  w_res = w_rol;
      4'd8:  w_res = {{(DW-1){1'b0}}, w_eq};
      4'd9:  w_res = {{(DW-1){1'b0}}, w_lt};
      4'd10: w_res = {{(DW-1){1'b0}}, w_lt | w_eq};
      4'd11: w_res = {{(DW-1){1'b0}}, w_sum[DW]};
      4'd12: begin
        if (w_taken) begin
          w_pcn = bus.pc + bus.imm;
          w_sel = 1'b1;
        end
      end
      4'd13: begin
        w_res = w_pc_inc;
        w_pcn = bus.a + bus.imm;
        w_sel = 1'b1;
      end
      default: w_res = '0;
    endcase
  end

  // Iterative units share r_mcand/r_mplier/r_acc; the last step is folded into the result.
  assign w_mul_acc = r_acc + (r_mplier[0] ? r_mcand : '0);

`ifdef EXEC_UNIT_DIV_EN
  logic [DW:0]   w_rem_sh;
  logic [DW:0]   w_rem_sub;
  logic          w_rem_ge;
  logic [DW-1:0] w_quo;

  // Restoring step: r_mcand = divisor, r_mplier = dividend shifting into quotient, r_acc = remainder.
  assign w_rem_sh  = {r_acc, r_mplier[DW-1]};
  assign w_rem_sub = w_rem_sh - {1'b0, r_mcand};
  assign w_rem_ge  = (w_rem_sh >= {1'b0, r_mcand});
  assign w_quo     = {r_mplier[DW-2:0], w_rem_ge};
  assign w_mc_res  = (r_state == S_DIV) ? w_quo : w_mul_acc;
`else
  assign w_mc_res  = w_mul_acc;
`endif

  always_comb begin
    w_state_nxt = r_state;
    if (bus.flush) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept && bus.op == 4'd14) w_state_nxt = S_MUL;
`ifdef EXEC_UNIT_DIV_EN
          else if (w_accept && bus.op == 4'd15) w_state_nxt = S_DIV;
`endif
        end
        default: if (w_last) w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_pc_next   <= '0;
      r_pc_sel    <= 1'b0;
      r_cnt       <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_acc       <= '0;
      r_mc_pcn    <= '0;
    end else begin
      if (bus.flush) begin
        r_out_valid <= 1'b0;
        r_pc_sel    <= 1'b0;
      end else if (w_accept && !w_is_mc) begin
        r_out_valid <= 1'b1;
        r_result    <= w_res;
        r_pc_next   <= w_pcn;
        r_pc_sel    <= w_sel;
      end else if (w_mc_done) begin
        r_out_valid <= 1'b1;
        r_result    <= w_mc_res;
        r_pc_next   <= r_mc_pcn;
        r_pc_sel    <= 1'b0;
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end

      if (w_accept && w_is_mc) begin
        r_cnt    <= '0;
        r_acc    <= '0;
        r_mc_pcn <= w_pc_inc;
`ifdef EXEC_UNIT_DIV_EN
        if (bus.op == 4'd15) begin
          r_mcand  <= bus.b;
          r_mplier <= bus.a;
        end else begin
          r_mcand  <= bus.a;
          r_mplier <= bus.b;
        end
`else
        r_mcand  <= bus.a;
        r_mplier <= bus.b;
`endif
      end else begin
        case (r_state)
          S_MUL: begin
            r_acc    <= w_mul_acc;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
          end
`ifdef EXEC_UNIT_DIV_EN
          S_DIV: begin
            r_acc    <= w_rem_ge ? w_rem_sub[DW-1:0] : w_rem_sh[DW-1:0];
            r_mplier <= w_quo;
            r_cnt    <= r_cnt + 1'b1;
          end
`endif
          default: ;
        endcase
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.pc_next   = r_pc_next;
  assign bus.pc_sel    = r_pc_sel;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_exec_unit_mc.sv
// Self-checking bench for exec_unit_mc (DW=16, PC_INC=2): reference model + expected queue.
module tb_exec_unit_mc;

  localparam int W = 16;
  typedef logic [2*W:0] exp_t;  // {result, pc_next, pc_sel}

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  logic rnd_ready;
  logic fixed_ready;
  exp_t exp_q[$];

  exec_unit_mc_if #(.DW(W)) bus ();

  exec_unit_mc #(.DW(W), .PC_INC(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [1:0] bc,
                                 input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [W-1:0] imm, input logic [W-1:0] pc);
    logic [W-1:0] r;
    logic [W-1:0] pn;
    logic         s;
    logic         tk;
    logic [W:0]   wide;
    logic [3:0]   sh;
    r  = '0;
    pn = pc + 16'd2;
    s  = 1'b0;
    sh = b[3:0];
    case (op)
      4'd0:  r = a + b;
      4'd1:  r = a - b;
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = a ^ b;
      4'd5:  r = a << sh;
      4'd6:  r = a >> sh;
      4'd7: begin
        r = a;
        for (int i = 0; i < int'(sh); i++) r = {r[W-2:0], r[W-1]};
      end
      4'd8:  r = (a == b) ? 16'd1 : 16'd0;
      4'd9:  r = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
      4'd10: r = ($signed(a) <= $signed(b)) ? 16'd1 : 16'd0;
      4'd11: begin
        wide = {1'b0, a} + {1'b0, b};
        r = wide[W] ? 16'd1 : 16'd0;
      end
      4'd12: begin
        case (bc)
          2'd0:    tk = (a == 16'd0);
          2'd1:    tk = (a != 16'd0);
          2'd2:    tk = ($signed(a) < 0);
          default: tk = ($signed(a) >= 0);
        endcase
        if (tk) begin
          pn = pc + imm;
          s  = 1'b1;
        end
      end
      4'd13: begin
        r  = pc + 16'd2;
        pn = a + imm;
        s  = 1'b1;
      end
      4'd14: r = a * b;
`ifdef EXEC_UNIT_DIV_EN
      default: r = (b == 16'd0) ? 16'hFFFF : a / b;
`else
      default: r = 16'd0;
`endif
    endcase
    return {r, pn, s};
  endfunction

  // Output ready: either a fixed level or random per cycle, changed just after the edge.
  always @(posedge clk) begin
    #2;
    bus.out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : fixed_ready;
  end

  // Scoreboard: every transferred result is compared against the head of exp_q.
  always @(negedge clk) begin
    exp_t e;
    if (rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", 64'(bus.result), 64'hDEAD);
      end else begin
        e = exp_q.pop_front();
        chk("sb_result", 64'(bus.result), 64'(e[2*W:W+1]));
        chk("sb_pc_next", 64'(bus.pc_next), 64'(e[W:1]));
        chk("sb_pc_sel", 64'(bus.pc_sel), 64'(e[0]));
      end
    end
  end

  // Drive one op; returns just after the accepting edge with the number of stalled cycles.
  task automatic send(input logic [3:0] op, input logic [1:0] bc, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic [W-1:0] imm, input logic [W-1:0] pc,
                      output int waited);
    waited = 0;
    @(negedge clk);
    bus.op = op; bus.brcond = bc; bus.a = a; bus.b = b; bus.imm = imm; bus.pc = pc;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 200) begin
      chk("send_timeout", 64'(waited), 64'd0);
      bus.in_valid = 1'b0;
    end else begin
      exp_q.push_back(model(op, bc, a, b, imm, pc));
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
    end
  endtask

  task automatic wait_valid(output int n, output int bad);
    n = 0;
    bad = 0;
    while (!bus.out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (!bus.out_valid && (bus.in_ready || !bus.busy)) bad++;
    end
  endtask

  task automatic wait_drain(input string tag);
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 500) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    chk(tag, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int w;
    int n;
    int bad;
    logic [W-1:0] held;
    n_checks = 0;
    n_fail = 0;
    rnd_ready = 1'b0;
    fixed_ready = 1'b1;
    rst = 1'b0;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.op = '0; bus.brcond = '0; bus.a = '0; bus.b = '0; bus.imm = '0; bus.pc = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_result", 64'(bus.result), 64'd0);
    chk("rst_pc_next", 64'(bus.pc_next), 64'd0);
    chk("rst_pc_sel", 64'(bus.pc_sel), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_state", 64'(bus.dbg_state), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Back-to-back single-cycle ops
    send(4'd1, 2'd0, 16'd5, 16'd7, 16'd0, 16'h0010, w);
    chk("sub_result", 64'(bus.result), 64'hFFFE);
    chk("sub_pc_next", 64'(bus.pc_next), 64'h0012);
    send(4'd9, 2'd0, 16'hFFFE, 16'h0001, 16'd0, 16'h0012, w);
    chk("b2b_stall_slt", 64'(w), 64'd0);
    chk("slt_result", 64'(bus.result), 64'd1);
    send(4'd11, 2'd0, 16'hFFFF, 16'h0001, 16'd0, 16'h0014, w);
    chk("b2b_stall_sco", 64'(w), 64'd0);
    chk("sco_result", 64'(bus.result), 64'd1);
    wait_drain("drain_b2b");

    // Multiplier latency and results
    send(4'd14, 2'd0, 16'h0123, 16'h0010, 16'd0, 16'h0020, w);
    wait_valid(n, bad);
    chk("mul_latency", 64'(n), 64'(W));
    chk("mul_inready_busy", 64'(bad), 64'd0);
    chk("mul_result", 64'(bus.result), 64'h1230);
    send(4'd14, 2'd0, 16'hFFFF, 16'hFFFF, 16'd0, 16'h0022, w);
    wait_valid(n, bad);
    chk("mul2_result", 64'(bus.result), 64'h0001);
    wait_drain("drain_mul");

    // Reset in the middle of a multiply
    send(4'd14, 2'd0, 16'h1234, 16'h0005, 16'd0, 16'h0030, w);
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rstmul_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rstmul_busy", 64'(bus.busy), 64'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstmul_in_ready", 64'(bus.in_ready), 64'd1);
    send(4'd0, 2'd0, 16'h7FFF, 16'h0001, 16'd0, 16'h0040, w);
    chk("add_after_rst", 64'(bus.result), 64'h8000);
    chk("add_after_rst_valid", 64'(bus.out_valid), 64'd1);
    wait_drain("drain_rst");

    // Branches and jump
    send(4'd12, 2'd0, 16'h0000, 16'd0, 16'hFFF0, 16'h0100, w);
    chk("br_eqz_pcn", 64'(bus.pc_next), 64'h00F0);
    chk("br_eqz_sel", 64'(bus.pc_sel), 64'd1);
    send(4'd12, 2'd1, 16'h0000, 16'd0, 16'hFFF0, 16'h0100, w);
    chk("br_nez_pcn", 64'(bus.pc_next), 64'h0102);
    chk("br_nez_sel", 64'(bus.pc_sel), 64'd0);
    send(4'd13, 2'd0, 16'h0200, 16'd0, 16'h0004, 16'h0100, w);
    chk("jr_pcn", 64'(bus.pc_next), 64'h0204);
    chk("jr_result", 64'(bus.result), 64'h0102);
    chk("jr_sel", 64'(bus.pc_sel), 64'd1);
    wait_drain("drain_br");

    // Backpressure then flush
    fixed_ready = 1'b0;
    @(posedge clk);
    #3;
    send(4'd12, 2'd0, 16'h0000, 16'd0, 16'h0008, 16'h0040, w);
    held = bus.result;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_valid", 64'(bus.out_valid), 64'd1);
      chk("bp_pc_next", 64'(bus.pc_next), 64'h0048);
      chk("bp_result", 64'(bus.result), 64'(held));
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
    end
    @(negedge clk);
    bus.flush = 1'b1;
    bus.in_valid = 1'b1;
    bus.op = 4'd0; bus.a = 16'd1; bus.b = 16'd1;
    chk("flush_in_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    exp_q.delete();
    chk("flush_valid", 64'(bus.out_valid), 64'd0);
    chk("flush_pc_sel", 64'(bus.pc_sel), 64'd0);
    chk("flush_pc_next_kept", 64'(bus.pc_next), 64'h0048);
    fixed_ready = 1'b1;
    @(posedge clk);
    #3;
    chk("flush_dropped", 64'(bus.out_valid), 64'd0);

    // Op 15
`ifdef EXEC_UNIT_DIV_EN
    send(4'd15, 2'd0, 16'd100, 16'd7, 16'd0, 16'h0050, w);
    wait_valid(n, bad);
    chk("div_latency", 64'(n), 64'(W));
    chk("div_inready_busy", 64'(bad), 64'd0);
    chk("div_result", 64'(bus.result), 64'd14);
    send(4'd15, 2'd0, 16'd5, 16'd0, 16'd0, 16'h0052, w);
    wait_valid(n, bad);
    chk("div0_result", 64'(bus.result), 64'hFFFF);
`else
    send(4'd15, 2'd0, 16'd100, 16'd7, 16'd0, 16'h0050, w);
    chk("op15_valid", 64'(bus.out_valid), 64'd1);
    chk("op15_result", 64'(bus.result), 64'd0);
`endif
    wait_drain("drain_op15");

    // Random ops with random output backpressure
    rnd_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      send(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 16'($urandom),
           16'($urandom), 16'($urandom), 16'($urandom), w);
    end
    rnd_ready = 1'b0;
    fixed_ready = 1'b1;
    wait_drain("drain_random");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
